// File: rtl/counter_pkg.sv
// counter_pkg: shared direction encodings and load clamping for updown_counter
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Load values at or above the modulus are pinned to the top of the count range.
    function automatic logic [63:0] clamp_load(input logic [63:0] d, input logic [63:0] modulus);
        return (d < modulus) ? d : modulus - 64'd1;
    endfunction

endpackage

// File: rtl/counter_next.sv
// counter_next: combinational next-count, wrap and terminal-count logic
//   a         current count
//   en/up     step enable and direction
//   load/d    parallel load (wins over en), value clamped to MODULUS-1
//   a_next    count for the next edge
//   wrap_next registered by the parent as the wrap pulse
//   tc        terminal count, drives the next stage's en when cascading
module counter_next
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              SATURATE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] a_next,
    output logic             wrap_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
    localparam bit               SAT = SATURATE != 0;

    logic             at_max;
    logic             at_zero;
    logic             out_of_range;
    logic [WIDTH-1:0] loaded;

    assign at_max       = a == MAX;
    assign at_zero      = a == '0;
    // Only reachable through an upset; the next step recovers to zero.
    assign out_of_range = 64'(a) >= MODULUS;
    assign loaded       = WIDTH'(clamp_load(64'(d), MODULUS));
    assign tc           = en & ~load & ((up == DIR_UP & at_max) | (up == DIR_DOWN & at_zero));

    always_comb begin
        a_next    = a;
        wrap_next = 1'b0;
        if (load) begin
            a_next = loaded;
        end else if (en && out_of_range) begin
            a_next = '0;
        end else if (en && up == DIR_UP) begin
            a_next    = at_max ? (SAT ? a : '0) : a + 1'b1;
            wrap_next = at_max & ~SAT;
        end else if (en) begin
            a_next    = at_zero ? (SAT ? a : MAX) : a - 1'b1;
            wrap_next = at_zero & ~SAT;
        end
    end

endmodule

// File: rtl/updown_counter.sv
// updown_counter: modulo-N up/down counter with load, enable and optional saturation
//   CLK      rising-edge clock
//   clear_b  asynchronous active-low reset (A=0, wrap=0)
//   en, up   count enable and direction (1 = up)
//   load, D  synchronous parallel load, priority over en
//   A        registered count
//   tc       combinational terminal count for cascading
//   wrap     one-cycle pulse after a wrap step
module updown_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter int              SATURATE = 0
) (
    input  logic             CLK,
    input  logic             clear_b,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] A,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 63) begin : g_bad_width
        $error("updown_counter: WIDTH must be in 1..63");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("updown_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
        $error("updown_counter: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] a_next;
    logic             wrap_next;

    counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .SATURATE(SATURATE)
    ) u_next (
        .a        (A),
        .en       (en),
        .up       (up),
        .load     (load),
        .d        (D),
        .a_next   (a_next),
        .wrap_next(wrap_next),
        .tc       (tc)
    );

    always_ff @(posedge CLK or negedge clear_b) begin
        if (!clear_b) begin
            A    <= '0;
            wrap <= 1'b0;
        end else begin
            A    <= a_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: scoreboard bench for wrap, saturate, load-clamp and cascade behaviour
module tb_updown_counter;

    typedef struct {
        logic [7:0] a;
        logic [1:0] w;
    } exp_t;

    typedef struct {
        logic       ld;
        logic [3:0] d;
        logic       en;
        logic       up;
        logic       tc;
        logic [3:0] a;
        logic       w;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       en0 = 1'b0, up0 = 1'b0, ld0 = 1'b0;
    logic [3:0] d0  = 4'd0;
    logic [3:0] a0;
    logic       tc0, w0;

    logic       en1 = 1'b0, up1 = 1'b0, ld1 = 1'b0;
    logic [3:0] d1  = 4'd0;
    logic [3:0] a1;
    logic       tc1, w1;

    logic       cen = 1'b0, cup = 1'b0, cld = 1'b0;
    logic [3:0] cd  = 4'd0;
    logic [3:0] a_lo, a_hi;
    logic       tc_lo, tc_hi, w_lo, w_hi;

    always #5 clk = ~clk;

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .CLK(clk), .clear_b(rst_n), .en(en0), .up(up0), .load(ld0), .D(d0),
        .A(a0), .tc(tc0), .wrap(w0)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .CLK(clk), .clear_b(rst_n), .en(en1), .up(up1), .load(ld1), .D(d1),
        .A(a1), .tc(tc1), .wrap(w1)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
        .CLK(clk), .clear_b(rst_n), .en(cen), .up(cup), .load(cld), .D(cd),
        .A(a_lo), .tc(tc_lo), .wrap(w_lo)
    );

    updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
        .CLK(clk), .clear_b(rst_n), .en(tc_lo), .up(cup), .load(cld), .D(cd),
        .A(a_hi), .tc(tc_hi), .wrap(w_hi)
    );

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a0 !== 4'd0 || w0 !== 1'b0 || a1 !== 4'd0 || a_lo !== 4'd0 || a_hi !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: A=%0d wrap=%b sat=%0d lo=%0d hi=%0d, required all 0", a0, w0, a1, a_lo, a_hi);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a0 !== 4'd0 || w0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: A=%0d wrap=%b, required A=0 wrap=0", a0, w0);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            en0 = 1'b1;
            up0 = 1'b1;
            sb.push_back('{a: 8'(i), w: 2'b00});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'h0, a0} !== e.a || {1'b0, w0} !== e.w) begin
                errors++;
                $display("FAIL reset_mid_count[%0d]: A=%0d wrap=%b, required A=%0d wrap=%b", i, a0, w0, e.a, e.w[0]);
            end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a0 !== 4'd0 || w0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: A=%0d wrap=%b, required A=0 wrap=0", a0, w0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (a0 !== 4'd0) begin
            errors++;
            $display("FAIL reset_held_low: A=%0d, required 0", a0);
        end
        @(negedge clk);
        en0   = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_decade_up();
        vec_t v[5];
        v = '{'{1'b1, 4'd8, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1},
              '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0},
              '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0}};
        foreach (v[i]) begin
            @(negedge clk);
            ld0 = v[i].ld; d0 = v[i].d; en0 = v[i].en; up0 = v[i].up;
            sb.push_back('{a: {4'h0, v[i].a}, w: {1'b0, v[i].w}});
            #1;
            checks++;
            if (tc0 !== v[i].tc) begin
                errors++;
                $display("FAIL decade_tc[%0d]: tc=%b, required %b", i, tc0, v[i].tc);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'h0, a0} !== e.a || {1'b0, w0} !== e.w) begin
                errors++;
                $display("FAIL decade_up[%0d]: A=%0d wrap=%b, required A=%0d wrap=%b", i, a0, w0, e.a, e.w[0]);
            end
        end
    endtask

    task automatic test_down_flip();
        vec_t v[5];
        v = '{'{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1},
              '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1},
              '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}};
        foreach (v[i]) begin
            @(negedge clk);
            ld0 = v[i].ld; d0 = v[i].d; en0 = v[i].en; up0 = v[i].up;
            sb.push_back('{a: {4'h0, v[i].a}, w: {1'b0, v[i].w}});
            #1;
            checks++;
            if (tc0 !== v[i].tc) begin
                errors++;
                $display("FAIL down_flip_tc[%0d]: tc=%b, required %b", i, tc0, v[i].tc);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'h0, a0} !== e.a || {1'b0, w0} !== e.w) begin
                errors++;
                $display("FAIL down_flip[%0d]: A=%0d wrap=%b, required A=%0d wrap=%b", i, a0, w0, e.a, e.w[0]);
            end
        end
    endtask

    task automatic test_load_clamp();
        vec_t v[5];
        v = '{'{1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 4'd9, 1'b0},
              '{1'b1, 4'd4,  1'b0, 1'b0, 1'b0, 4'd4, 1'b0},
              '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd4, 1'b0},
              '{1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0},
              '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0, 1'b1}};
        foreach (v[i]) begin
            @(negedge clk);
            ld0 = v[i].ld; d0 = v[i].d; en0 = v[i].en; up0 = v[i].up;
            sb.push_back('{a: {4'h0, v[i].a}, w: {1'b0, v[i].w}});
            #1;
            checks++;
            if (tc0 !== v[i].tc) begin
                errors++;
                $display("FAIL load_clamp_tc[%0d]: tc=%b, required %b", i, tc0, v[i].tc);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'h0, a0} !== e.a || {1'b0, w0} !== e.w) begin
                errors++;
                $display("FAIL load_clamp[%0d]: A=%0d wrap=%b, required A=%0d wrap=%b", i, a0, w0, e.a, e.w[0]);
            end
        end
        @(negedge clk);
        ld0 = 1'b0;
        en0 = 1'b0;
    endtask

    task automatic test_saturate();
        vec_t v[7];
        v = '{'{1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd8, 1'b0},
              '{1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0},
              '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0}};
        foreach (v[i]) begin
            @(negedge clk);
            ld1 = v[i].ld; d1 = v[i].d; en1 = v[i].en; up1 = v[i].up;
            sb.push_back('{a: {4'h0, v[i].a}, w: {1'b0, v[i].w}});
            #1;
            checks++;
            if (tc1 !== v[i].tc) begin
                errors++;
                $display("FAIL saturate_tc[%0d]: tc=%b, required %b", i, tc1, v[i].tc);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({4'h0, a1} !== e.a || {1'b0, w1} !== e.w) begin
                errors++;
                $display("FAIL saturate[%0d]: A=%0d wrap=%b, required A=%0d wrap=%b", i, a1, w1, e.a, e.w[0]);
            end
        end
        @(negedge clk);
        en1 = 1'b0;
    endtask

    task automatic test_cascade();
        int n;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            cen = 1'b1;
            cup = 1'b1;
            n = i + 1;
            sb.push_back('{a: {4'(n / 10), 4'(n % 10)}, w: {1'b0, (n % 10) == 0}});
            #1;
            checks++;
            if (tc_lo !== ((i % 10) == 9)) begin
                errors++;
                $display("FAIL cascade_tc_lo[%0d]: tc=%b, required %b", i, tc_lo, (i % 10) == 9);
            end
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({a_hi, a_lo} !== e.a || {w_hi, w_lo} !== e.w) begin
                errors++;
                $display("FAIL cascade_count[%0d]: hi.lo=%0d.%0d wraps=%b, required %h wraps=%b", i, a_hi, a_lo, {w_hi, w_lo}, e.a, e.w);
            end
        end
        @(negedge clk);
        cen = 1'b0; cld = 1'b1; cd = 4'd9;
        sb.push_back('{a: 8'h99, w: 2'b00});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_hi, a_lo} !== e.a || {w_hi, w_lo} !== e.w) begin
            errors++;
            $display("FAIL cascade_load99: hi.lo=%0d.%0d wraps=%b, required %h wraps=%b", a_hi, a_lo, {w_hi, w_lo}, e.a, e.w);
        end
        @(negedge clk);
        cld = 1'b0; cen = 1'b1;
        sb.push_back('{a: 8'h00, w: 2'b11});
        #1;
        checks++;
        if (tc_lo !== 1'b1 || tc_hi !== 1'b1) begin
            errors++;
            $display("FAIL cascade_tc_99: tc_hi=%b tc_lo=%b, required 1 1", tc_hi, tc_lo);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_hi, a_lo} !== e.a || {w_hi, w_lo} !== e.w) begin
            errors++;
            $display("FAIL cascade_rollover: hi.lo=%0d.%0d wraps=%b, required %h wraps=%b", a_hi, a_lo, {w_hi, w_lo}, e.a, e.w);
        end
        @(negedge clk);
        sb.push_back('{a: 8'h01, w: 2'b00});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({a_hi, a_lo} !== e.a || {w_hi, w_lo} !== e.w) begin
            errors++;
            $display("FAIL cascade_after_roll: hi.lo=%0d.%0d wraps=%b, required %h wraps=%b", a_hi, a_lo, {w_hi, w_lo}, e.a, e.w);
        end
        @(negedge clk);
        cen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_decade_up();
        test_down_flip();
        test_load_clamp();
        test_saturate();
        test_cascade();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
